muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Sequencer sitting between the main control FSM and the mult/div units plus the HIGH/LOW registers. On a request it issues the one-cycle start strobe to the selected unit and waits for that unit's end flag. It then steers the HIGH/LOW input muxes and write-enables, and reports completion, divide-by-zero or timeout back to control. This frees the control FSM from per-unit wait states.

Parameters:
TIMEOUT, 40, max WAIT cycles before a timeout exception; legal range 1..2^CNT_W-1
CNT_W, 6, width of the cycle counter and the cycles output

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  1  start request from control; sampled only in IDLE
op  input  1  0 = mult, 1 = div; latched with req
mult_end  input  1  end flag from mult unit
div_end  input  1  end flag from div unit
div_zero  input  1  divide-by-zero flag from div unit
mult_start  output  1  one-cycle start strobe to mult unit
div_start  output  1  one-cycle start strobe to div unit
muxhigh  output  1  HIGH input mux select (0 mult, 1 div)
muxlow  output  1  LOW input mux select (0 mult, 1 div)
highwrite  output  1  HIGH register load enable
lowwrite  output  1  LOW register load enable
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, coincident with highwrite/lowwrite
div_zero_exc  output  1  one-cycle divide-by-zero exception pulse
timeout_exc  output  1  one-cycle timeout exception pulse
cycles  output  CNT_W  WAIT-cycle count of the last successful operation

Behaviour:
- Reset (sync, active-high): state IDLE; every output 0, including cycles; latched op = 0. Reset mid-operation aborts immediately, with no HI/LO write and no done or exception pulse.
- States: IDLE, START, WAIT, WRITE, EXC.
- IDLE:
  - busy = 0.
  - req = 1: latch op, go to START next cycle.
  - req = 0: stay in IDLE.
- START:
  - Exactly one cycle.
  - mult_start = 1 if op = 0, else div_start = 1; the other strobe stays 0.
  - Counter cleared to 0. Next state WAIT.
- WAIT:
  - Each cycle, counter increments by 1. Let n be the incremented value.
  - op = 1 and div_zero = 1: go to EXC(divzero). div_zero beats div_end in the same cycle.
  - Otherwise, end flag of the selected unit = 1: cycles <= n, go to WRITE.
  - Otherwise, n = TIMEOUT: go to EXC(timeout).
  - Otherwise: stay in WAIT.
  - End flags from the non-selected unit are ignored. div_zero is ignored when op = 0.
- WRITE:
  - Exactly one cycle.
  - highwrite = lowwrite = done = 1.
  - Next state IDLE.
- EXC:
  - Exactly one cycle.
  - Pulses div_zero_exc or timeout_exc, never both.
  - highwrite, lowwrite and done stay 0; cycles unchanged.
  - Next state IDLE.
- muxhigh = muxlow = latched op in START, WAIT and WRITE; 0 in IDLE and EXC.
- req while busy is ignored; there is no queueing, so the requester reissues after done or an exception.
- Minimum latency:
  - req at cycle t gives start strobe at t+1.
  - First WAIT cycle is t+2.
  - End flag seen at t+2 gives done at t+3.
  - In general, done = t + 2 + cycles.
- Back-to-back: a new req may be accepted in the IDLE cycle that immediately follows WRITE or EXC.
- All outputs are registered-state decodes and glitch-free; no output depends combinationally on req.

Test Plan:
- Reset, then req=1, op=0 at cycle 0; mult_end=1 at cycle 34 -> mult_start only at cycle 1; highwrite=lowwrite=done=1 at cycle 35 with muxhigh=muxlow=0; cycles=33; busy=0 at cycle 36.
- req=1, op=1; div_end=1 at 5th WAIT cycle -> div_start once; done with muxhigh=muxlow=1; cycles=5.
- req=1, op=1; div_zero=1 and div_end=1 together at 3rd WAIT cycle -> div_zero_exc pulse only; no highwrite, lowwrite or done; cycles keeps its previous value.
- req=1, op=0; mult_end held 0; TIMEOUT=40 -> timeout_exc at the cycle after the 40th WAIT cycle; no write; then IDLE.
- req=1, op=0; div_end=1 during WAIT; extra req pulses while busy -> div_end ignored; extra reqs produce no second strobe; completes only on mult_end.
- reset=1 during the 10th WAIT cycle -> next cycle all outputs 0 and state IDLE; new req accepted immediately after.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Purpose:
//   Sits between the main control FSM and the multiply/divide units plus the
//   HIGH/LOW registers. On a request it strobes the selected unit's start for
//   one cycle, waits for that unit's end flag, and then loads HIGH/LOW from
//   that unit. It reports one of three outcomes to control: done,
//   divide-by-zero, or timeout.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset (aborts any operation)
//   req          start request, sampled only in IDLE
//   op           0 = mult, 1 = div, latched together with req
//   mult_end     end flag from the mult unit
//   div_end      end flag from the div unit
//   div_zero     divide-by-zero flag from the div unit
//   mult_start   one-cycle start strobe to the mult unit
//   div_start    one-cycle start strobe to the div unit
//   muxhigh      HIGH input mux select (0 mult, 1 div)
//   muxlow       LOW input mux select (0 mult, 1 div)
//   highwrite    HIGH register load enable
//   lowwrite     LOW register load enable
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse, coincident with the writes
//   div_zero_exc one-cycle divide-by-zero exception pulse
//   timeout_exc  one-cycle timeout exception pulse
//   cycles       WAIT-cycle count of the last successful operation
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             op,
    input  logic             mult_end,
    input  logic             div_end,
    input  logic             div_zero,
    output logic             mult_start,
    output logic             div_start,
    output logic             muxhigh,
    output logic             muxlow,
    output logic             highwrite,
    output logic             lowwrite,
    output logic             busy,
    output logic             done,
    output logic             div_zero_exc,
    output logic             timeout_exc,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_WRITE,
        S_EXC
    } state_t;

    state_t           r_state, w_state_next;
    logic             r_op, w_op_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_cycles, w_cycles_next;
    // Remembers which exception EXC must report: 1 = divide-by-zero, 0 = timeout.
    logic             r_exc_zero, w_exc_zero_next;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_end_sel;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Only the end flag of the unit actually started is ever looked at.
    assign w_end_sel = r_op ? div_end : mult_end;
    assign cycles    = r_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= 1'b0;
            r_cnt      <= '0;
            r_cycles   <= '0;
            r_exc_zero <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_op       <= w_op_next;
            r_cnt      <= w_cnt_next;
            r_cycles   <= w_cycles_next;
            r_exc_zero <= w_exc_zero_next;
        end
    end

    // Next-state logic plus output decode. Outputs depend only on registered
    // state and the latched op, never on req, so they are clean decodes.
    always_comb begin
        w_state_next    = r_state;
        w_op_next       = r_op;
        w_cnt_next      = r_cnt;
        w_cycles_next   = r_cycles;
        w_exc_zero_next = r_exc_zero;

        mult_start   = 1'b0;
        div_start    = 1'b0;
        muxhigh      = 1'b0;
        muxlow       = 1'b0;
        highwrite    = 1'b0;
        lowwrite     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        div_zero_exc = 1'b0;
        timeout_exc  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_op_next    = op;
                    w_state_next = S_START;
                end
            end

            S_START: begin
                busy         = 1'b1;
                muxhigh      = r_op;
                muxlow       = r_op;
                mult_start   = ~r_op;
                div_start    = r_op;
                w_cnt_next   = '0;
                w_state_next = S_WAIT;
            end

            S_WAIT: begin
                busy       = 1'b1;
                muxhigh    = r_op;
                muxlow     = r_op;
                w_cnt_next = w_cnt_inc;
                // Divide-by-zero takes priority over a simultaneous div_end,
                // and a real end flag wins over a coincident timeout.
                if (r_op && div_zero) begin
                    w_exc_zero_next = 1'b1;
                    w_state_next    = S_EXC;
                end else if (w_end_sel) begin
                    w_cycles_next = w_cnt_inc;
                    w_state_next  = S_WRITE;
                end else if (w_cnt_inc == TIMEOUT_C) begin
                    w_exc_zero_next = 1'b0;
                    w_state_next    = S_EXC;
                end
            end

            S_WRITE: begin
                busy         = 1'b1;
                muxhigh      = r_op;
                muxlow       = r_op;
                highwrite    = 1'b1;
                lowwrite     = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end

            S_EXC: begin
                busy         = 1'b1;
                div_zero_exc = r_exc_zero;
                timeout_exc  = ~r_exc_zero;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed testbench for muldiv_sequencer. Each operation is walked cycle by
// cycle; the ten 1-bit outputs are packed into one vector and compared against
// hand-derived per-state patterns, with cycles checked separately.
// Packed order: {mult_start, div_start, muxhigh, muxlow, highwrite, lowwrite,
//                busy, done, div_zero_exc, timeout_exc}
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int TIMEOUT = 40;
    localparam int CNT_W   = 6;

    // Expected output patterns per state.
    localparam logic [9:0] P_IDLE      = 10'b00_00_00_0000;
    localparam logic [9:0] P_START_MUL = 10'b10_00_00_1000;
    localparam logic [9:0] P_START_DIV = 10'b01_11_00_1000;
    localparam logic [9:0] P_WAIT_MUL  = 10'b00_00_00_1000;
    localparam logic [9:0] P_WAIT_DIV  = 10'b00_11_00_1000;
    localparam logic [9:0] P_WRITE_MUL = 10'b00_00_11_1100;
    localparam logic [9:0] P_WRITE_DIV = 10'b00_11_11_1100;
    localparam logic [9:0] P_EXC_ZERO  = 10'b00_00_00_1010;
    localparam logic [9:0] P_EXC_TMO   = 10'b00_00_00_1001;

    logic             clk = 1'b0;
    logic             reset, req, op, mult_end, div_end, div_zero;
    logic             mult_start, div_start, muxhigh, muxlow;
    logic             highwrite, lowwrite, busy, done, div_zero_exc, timeout_exc;
    logic [CNT_W-1:0] cycles;
    logic [9:0]       outs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .op           (op),
        .mult_end     (mult_end),
        .div_end      (div_end),
        .div_zero     (div_zero),
        .mult_start   (mult_start),
        .div_start    (div_start),
        .muxhigh      (muxhigh),
        .muxlow       (muxlow),
        .highwrite    (highwrite),
        .lowwrite     (lowwrite),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .timeout_exc  (timeout_exc),
        .cycles       (cycles)
    );

    assign outs = {mult_start, div_start, muxhigh, muxlow, highwrite, lowwrite,
                   busy, done, div_zero_exc, timeout_exc};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled there
    // and inputs driven there apply to the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation starting from an IDLE cycle. end_wait = 0 means
    // the end flag never arrives (timeout). Returns on the final-state cycle
    // plus one, i.e. in the IDLE cycle that follows.
    task automatic run_op(input string name, input logic op_i, input int end_wait,
                          input logic zero, input logic wrong_end, input logic req_spam,
                          input logic [9:0] exp_final, input int exp_cycles);
        int n_wait;
        logic [9:0] p_start, p_wait;
        p_start = op_i ? P_START_DIV : P_START_MUL;
        p_wait  = op_i ? P_WAIT_DIV  : P_WAIT_MUL;
        n_wait  = (end_wait > 0) ? end_wait : TIMEOUT;

        check_eq({name, "_idle"}, 32'(outs), 32'(P_IDLE));
        req = 1'b1;
        op  = op_i;
        tick();
        check_eq({name, "_start"}, 32'(outs), 32'(p_start));
        req = 1'b0;
        op  = 1'b0;
        for (int w = 1; w <= n_wait; w++) begin
            tick();
            check_eq($sformatf("%s_wait%0d", name, w), 32'(outs), 32'(p_wait));
            if (wrong_end) begin
                if (op_i) mult_end = 1'b1;
                else      div_end  = 1'b1;
            end
            if (req_spam) req = w[0];
            if (w == end_wait) begin
                if (op_i) div_end = 1'b1;
                else      mult_end = 1'b1;
                div_zero = zero;
            end
        end
        tick();
        req = 1'b0; mult_end = 1'b0; div_end = 1'b0; div_zero = 1'b0;
        check_eq({name, "_final"}, 32'(outs), 32'(exp_final));
        check_eq({name, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        tick();
        $display("txn %s op=%0d end_wait=%0d cycles=%0d", name, op_i, end_wait, cycles);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b0; op = 1'b0;
        mult_end = 1'b0; div_end = 1'b0; div_zero = 1'b0;
        tick();
        tick();
        check_eq("reset_outs", 32'(outs), 32'(P_IDLE));
        check_eq("reset_cycles", 32'(cycles), 32'd0);
        reset = 1'b0;
        $display("txn reset outs=0x%0h cycles=%0d", outs, cycles);

        // mult, end flag on the 33rd WAIT cycle: done at req+35.
        run_op("mul33", 1'b0, 33, 1'b0, 1'b0, 1'b0, P_WRITE_MUL, 33);
        // div, end on 5th WAIT cycle; issued back-to-back.
        run_op("div5", 1'b1, 5, 1'b0, 1'b0, 1'b0, P_WRITE_DIV, 5);
        // div_zero together with div_end: exception only, cycles kept.
        run_op("divzero", 1'b1, 3, 1'b1, 1'b0, 1'b0, P_EXC_ZERO, 5);
        // mult never ends: timeout after the 40th WAIT cycle, cycles kept.
        run_op("timeout", 1'b0, 0, 1'b0, 1'b0, 1'b0, P_EXC_TMO, 5);
        // mult with div_end and div_zero noise plus req pulses while busy.
        div_zero = 1'b0;
        run_op("mulnoise", 1'b0, 7, 1'b1, 1'b1, 1'b1, P_WRITE_MUL, 7);

        // Reset during the 10th WAIT cycle aborts the operation.
        check_eq("abort_idle", 32'(outs), 32'(P_IDLE));
        req = 1'b1; op = 1'b0;
        tick();
        check_eq("abort_start", 32'(outs), 32'(P_START_MUL));
        req = 1'b0;
        for (int w = 1; w <= 10; w++) begin
            tick();
            check_eq($sformatf("abort_wait%0d", w), 32'(outs), 32'(P_WAIT_MUL));
        end
        reset = 1'b1;
        tick();
        check_eq("abort_outs", 32'(outs), 32'(P_IDLE));
        check_eq("abort_cycles", 32'(cycles), 32'd0);
        reset = 1'b0;
        $display("txn abort outs=0x%0h cycles=%0d", outs, cycles);
        // New request accepted right away.
        run_op("postreset", 1'b1, 2, 1'b0, 1'b0, 1'b0, P_WRITE_DIV, 2);
        check_eq("end_idle", 32'(outs), 32'(P_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
